// File: rtl/sd_ddr_rx_deframer_if.sv
// Bus bundle between the SD DAT[3:0] DDR capture cells / host logic and the
// receive deframer: captured nibbles and arm in, byte stream and status out.
interface sd_ddr_rx_deframer_if;
   logic [3:0] q0;
   logic [3:0] q1;
   logic       arm;
   logic       busy;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       block_done;
   logic       crc_err;
   logic       end_err;
   logic       timeout;

   modport master (
      output q0, q1, arm,
      input  busy, byte_data, byte_valid, block_done, crc_err, end_err, timeout
   );

   modport slave (
      input  q0, q1, arm,
      output busy, byte_data, byte_valid, block_done, crc_err, end_err, timeout
   );
endinterface

// File: rtl/sd_ddr_rx_deframer.sv
// SD 4-bit DDR read-block deframer: waits for the start bit, emits BLOCK_BYTES
// bytes, checks 8 per-lane/per-edge CRC16-CCITT streams and the end bit.
module sd_ddr_rx_deframer #(
   parameter int BLOCK_BYTES    = 512,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic                 clk,
   input logic                 RSTB,
   sd_ddr_rx_deframer_if.slave bus
);
   localparam int BCW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLOCK_BYTES - 1);
   localparam logic [TCW-1:0] LAST_WAIT = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_DATA,
      ST_CRC,
      ST_END
   } state_t;

   state_t            state_q, state_d;
   logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [TCW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0][15:0]  crc_q, crc_d;
   logic [7:0]        byte_data_q, byte_data_d;
   logic              byte_valid_q, byte_valid_d;
   logic              busy_q, busy_d;
   logic              block_done_q, block_done_d;
   logic              timeout_q, timeout_d;
   logic              crc_err_q, crc_err_d;
   logic              end_err_q, end_err_d;

   // One serial step of CRC16-CCITT (x^16+x^12+x^5+1), data fed at the top.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      crc_d        = crc_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      busy_d       = busy_q;
      block_done_d = 1'b0;
      timeout_d    = 1'b0;
      crc_err_d    = crc_err_q;
      end_err_d    = end_err_q;

      // Streams 0..3 follow the rising-edge nibble, 4..7 the falling-edge one.
      if (state_q == ST_DATA || state_q == ST_CRC) begin
         for (int n = 0; n < 4; n++) begin
            crc_d[n]     = crc16_step(crc_q[n], bus.q0[n]);
            crc_d[n + 4] = crc16_step(crc_q[n + 4], bus.q1[n]);
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.arm) begin
               state_d    = ST_WAIT_START;
               busy_d     = 1'b1;
               crc_err_d  = 1'b0;
               end_err_d  = 1'b0;
               wait_cnt_d = '0;
               crc_d      = '0;
            end
         end
         ST_WAIT_START: begin
            if (bus.q0 == 4'h0 && bus.q1 == 4'h0) begin
               state_d    = ST_DATA;
               byte_cnt_d = '0;
            end else if (wait_cnt_q == LAST_WAIT) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               busy_d    = 1'b0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            byte_data_d  = {bus.q0, bus.q1};
            byte_valid_d = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
               state_d   = ST_CRC;
               bit_cnt_d = '0;
            end else begin
               byte_cnt_d = byte_cnt_q + 1'b1;
            end
         end
         ST_CRC: begin
            if (bit_cnt_q == 4'd15) begin
               state_d = ST_END;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_END: begin
            end_err_d    = !(bus.q0 == 4'hF && bus.q1 == 4'hF);
            crc_err_d    = (crc_q != '0);
            block_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RSTB) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         crc_q        <= '0;
         byte_data_q  <= 8'h00;
         byte_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         block_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         crc_err_q    <= 1'b0;
         end_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         crc_q        <= crc_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         busy_q       <= busy_d;
         block_done_q <= block_done_d;
         timeout_q    <= timeout_d;
         crc_err_q    <= crc_err_d;
         end_err_q    <= end_err_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.byte_data  = byte_data_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.block_done = block_done_q;
   assign bus.timeout    = timeout_q;
   assign bus.crc_err    = crc_err_q;
   assign bus.end_err    = end_err_q;
endmodule

// File: tb/tb_sd_ddr_rx_deframer.sv
// Scoreboard bench for sd_ddr_rx_deframer: the driver queues expected bytes,
// block results and timeouts; a negedge monitor pops and compares them.
module tb_sd_ddr_rx_deframer;
   localparam int BB = 4;
   localparam int TO = 8;

   typedef struct { int cyc; logic [7:0] data; } byte_exp_t;
   typedef struct { int cyc; logic crc_err; logic end_err; } done_exp_t;

   logic clk = 1'b0;
   logic RSTB;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   byte_exp_t byte_q[$];
   done_exp_t done_q[$];
   int        to_q[$];

   sd_ddr_rx_deframer_if bus();

   sd_ddr_rx_deframer #(.BLOCK_BYTES(BB), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .RSTB(RSTB),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Remainder of the bit sequence (MSB first) as a GF(2) polynomial modulo G.
   function automatic logic [15:0] poly_mod(input bit b[$]);
      logic [16:0] r;
      r = '0;
      foreach (b[i]) begin
         r = {r[15:0], b[i]};
         if (r[16]) r = r ^ 17'h11021;
      end
      return r[15:0];
   endfunction

   // Inputs set now are captured at the next rising edge; returns 1 after it.
   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic armv);
      bus.q0  = a;
      bus.q1  = b;
      bus.arm = armv;
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [7:0] d [BB], input int idle, input int flip_s,
                             input int flip_i, input logic [3:0] e0, input logic [3:0] e1,
                             input int rearm_byte);
      bit          s [8][$];
      bit          aug[$];
      logic [15:0] crc [8];
      logic [3:0]  a, b;
      byte_exp_t   be;
      done_exp_t   de;
      logic        any_bad;

      drive(4'hF, 4'hF, 1'b1);
      check("busy after arm", bus.busy, 1'b1);
      check("crc_err cleared by arm", bus.crc_err, 1'b0);
      check("end_err cleared by arm", bus.end_err, 1'b0);
      repeat (idle) drive(4'hF, 4'hF, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
      for (int j = 0; j < BB; j++) begin
         for (int n = 0; n < 4; n++) begin
            s[n].push_back(d[j][4 + n]);
            s[n + 4].push_back(d[j][n]);
         end
         be.cyc = cyc + 1;
         be.data = d[j];
         byte_q.push_back(be);
         drive(d[j][7:4], d[j][3:0], j == rearm_byte);
      end
      for (int k = 0; k < 8; k++) begin
         aug = s[k];
         repeat (16) aug.push_back(1'b0);
         crc[k] = poly_mod(aug);
      end
      for (int i = 0; i < 16; i++) begin
         for (int n = 0; n < 4; n++) begin
            a[n] = crc[n][15 - i] ^ (flip_s == n && flip_i == i);
            b[n] = crc[n + 4][15 - i] ^ (flip_s == n + 4 && flip_i == i);
            s[n].push_back(a[n]);
            s[n + 4].push_back(b[n]);
         end
         drive(a, b, 1'b0);
      end
      any_bad = 1'b0;
      for (int k = 0; k < 8; k++) if (poly_mod(s[k]) != 16'h0000) any_bad = 1'b1;
      de.cyc = cyc + 1;
      de.crc_err = any_bad;
      de.end_err = !(e0 == 4'hF && e1 == 4'hF);
      done_q.push_back(de);
      drive(e0, e1, 1'b0);
      drive(4'hF, 4'hF, 1'b0);
   endtask

   task automatic wait_timeout(input bit random_lanes);
      logic [3:0] a, b;
      to_q.push_back(cyc + TO + 1);
      drive(4'hF, 4'hF, 1'b1);
      for (int i = 0; i < TO + 3; i++) begin
         if (i == TO - 1) check("busy before timeout", bus.busy, 1'b1);
         a = random_lanes ? 4'($urandom_range(0, 15)) : 4'hF;
         b = random_lanes ? 4'($urandom_range(0, 15)) : 4'hF;
         if (a == 4'h0 && b == 4'h0) a = 4'h8;
         drive(a, b, 1'b0);
      end
   endtask

   always @(negedge clk) begin : monitor
      byte_exp_t be;
      done_exp_t de;
      int        tc;
      if (bus.byte_valid) begin
         if (byte_q.size() == 0) check("byte_valid unexpected", bus.byte_valid, 1'b0);
         else begin
            be = byte_q.pop_front();
            check("byte_data", bus.byte_data, be.data);
            check("byte_valid cycle", cyc, be.cyc);
         end
      end
      if (bus.block_done) begin
         check("busy low at block_done", bus.busy, 1'b0);
         if (done_q.size() == 0) check("block_done unexpected", bus.block_done, 1'b0);
         else begin
            de = done_q.pop_front();
            check("block_done cycle", cyc, de.cyc);
            check("crc_err", bus.crc_err, de.crc_err);
            check("end_err", bus.end_err, de.end_err);
         end
      end
      if (bus.timeout) begin
         check("busy low at timeout", bus.busy, 1'b0);
         if (to_q.size() == 0) check("timeout unexpected", bus.timeout, 1'b0);
         else begin
            tc = to_q.pop_front();
            check("timeout cycle", cyc, tc);
         end
      end
   end

   initial begin
      logic [7:0] blk [BB];
      logic [3:0] e0, e1;
      int         fs;
      int         rb;

      RSTB    = 1'b1;
      bus.q0  = 4'hF;
      bus.q1  = 4'hF;
      bus.arm = 1'b0;
      drive(4'hF, 4'hF, 1'b0);
      drive(4'hF, 4'hF, 1'b1);
      check("reset busy", bus.busy, 1'b0);
      check("reset byte_valid", bus.byte_valid, 1'b0);
      check("reset byte_data", bus.byte_data, 8'h00);
      check("reset block_done", bus.block_done, 1'b0);
      check("reset timeout", bus.timeout, 1'b0);
      check("reset crc_err", bus.crc_err, 1'b0);
      check("reset end_err", bus.end_err, 1'b0);
      RSTB = 1'b0;
      drive(4'hF, 4'hF, 1'b0);
      drive(4'h0, 4'h0, 1'b0);
      check("arm during reset ignored", bus.busy, 1'b0);

      blk = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
      send_block(blk, 2, -1, 0, 4'hF, 4'hF, -1);
      send_block(blk, 2, 6, 9, 4'hF, 4'hF, -1);
      check("crc_err held after block", bus.crc_err, 1'b1);
      send_block(blk, 2, -1, 0, 4'hF, 4'hE, -1);
      check("end_err held after block", bus.end_err, 1'b1);
      wait_timeout(1'b0);

      drive(4'hF, 4'hF, 1'b1);
      drive(4'h0, 4'h0, 1'b0);
      byte_q.push_back('{cyc + 1, blk[0]});
      drive(blk[0][7:4], blk[0][3:0], 1'b0);
      RSTB = 1'b1;
      drive(blk[1][7:4], blk[1][3:0], 1'b0);
      RSTB = 1'b0;
      check("busy after mid-block reset", bus.busy, 1'b0);
      repeat (24) drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      send_block(blk, 2, -1, 0, 4'hF, 4'hF, -1);
      send_block(blk, 2, -1, 0, 4'hF, 4'hF, 2);

      for (int t = 0; t < 10; t++) begin
         for (int j = 0; j < BB; j++) blk[j] = 8'($urandom_range(0, 255));
         fs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         e0 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         e1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         rb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BB - 1)) : -1;
         send_block(blk, int'($urandom_range(0, 5)), fs, int'($urandom_range(0, 15)), e0, e1, rb);
      end
      wait_timeout(1'b1);

      repeat (4) drive(4'hF, 4'hF, 1'b0);
      check("bytes outstanding", byte_q.size(), 0);
      check("block_done outstanding", done_q.size(), 0);
      check("timeouts outstanding", to_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sd_ddr_rx_deframer.md
SD_DDR_RX_DEFRAMER -- requirements
Module: sd_ddr_rx_deframer

Interface
REQ-001 Parameter BLOCK_BYTES, default 512: data bytes per block, legal range 1..4096.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: maximum clk cycles to wait for a start bit, legal range 1..65535.
REQ-003 clk  in  1  SD clock domain; same clock that drives SCLK of the four input DDR capture cells.
REQ-004 RSTB  in  1  reset, synchronous, active-high.
REQ-005 q0  in  4  rising-edge nibble from DAT[3:0] capture cells, bit n = DAT[n].
REQ-006 q1  in  4  falling-edge nibble from the same cells, same cycle as q0.
REQ-007 arm  in  1  single-cycle pulse: expect one block.
REQ-008 busy  out  1  high from the cycle after an accepted arm until the cycle block_done or timeout asserts.
REQ-009 byte_data  out  8  received byte.
REQ-010 byte_valid  out  1  single-cycle qualifier for byte_data.
REQ-011 block_done  out  1  single-cycle pulse at block end.
REQ-012 crc_err  out  1  CRC result, valid with block_done, held until the next accepted arm.
REQ-013 end_err  out  1  end-bit result, valid with block_done, held until the next accepted arm.
REQ-014 timeout  out  1  single-cycle pulse: no start bit within TIMEOUT_CYCLES.

Function
REQ-015 States shall be IDLE, WAIT_START, DATA, CRC, END.
REQ-016 IDLE: arm=1 shall clear crc_err, end_err, the timeout counter and all CRC registers, and go to WAIT_START next cycle.
REQ-017 arm shall be ignored in any state other than IDLE.
REQ-018 WAIT_START: a cycle with q0==4'h0 and q1==4'h0 shall be the start bit; the FSM shall go to DATA and the byte counter shall clear.
REQ-019 WAIT_START: any other pattern shall increment the timeout counter.
REQ-020 WAIT_START: when the counter reaches TIMEOUT_CYCLES with no start bit, the block shall pulse timeout for one cycle and return to IDLE, with no block_done.
REQ-021 DATA: each cycle shall form the byte {q0[3:0], q1[3:0]} (bit7=q0[3], bit0=q1[0]).
REQ-022 DATA: the byte shall be presented on byte_data with byte_valid=1 exactly one cycle later (registered, latency 1).
REQ-023 DATA shall last exactly BLOCK_BYTES consecutive cycles with no gaps, then go to CRC.
REQ-024 CRC streams: 8 independent serial CRC16-CCITT registers (poly x^16+x^12+x^5+1, init 16'h0000), one per lane n and edge e.
REQ-025 Per DATA cycle, stream (n, rising) shall shift in q0[n] and stream (n, falling) shall shift in q1[n].
REQ-026 CRC: for exactly 16 cycles the received bits shall continue shifting into the same registers, same lane/edge mapping, MSB first; then go to END.
REQ-027 END: one cycle. end_err shall be set unless q0==4'hF and q1==4'hF.
REQ-028 END: crc_err shall be set unless all 8 registers equal 16'h0000.
REQ-029 END: the FSM shall go to IDLE.
REQ-030 block_done shall pulse in the cycle after END, with crc_err and end_err already valid; busy shall deassert in that same cycle.
REQ-031 The byte counter and timeout counter widths shall be derived from the parameters with no wrap-around before terminal count.
REQ-032 byte_valid shall never assert outside the BLOCK_BYTES window; the last byte_valid shall coincide with the first CRC cycle.

Reset
REQ-033 RSTB=1 at a clk edge shall force IDLE, clear all counters and CRC registers, and drive busy, byte_valid, block_done, timeout, crc_err and end_err to 0 and byte_data to 8'h00.
REQ-034 Reset asserted mid-block (DATA/CRC/END) shall abort the block silently: no block_done, no further byte_valid.
REQ-035 arm coincident with RSTB=1 shall be ignored.

Verification (BLOCK_BYTES=4, TIMEOUT_CYCLES=8)
REQ-036 Scenario: arm; 2 idle cycles q0=q1=F; start; data bytes A5,3C,00,FF; 16 cycles of correct per-stream CRC; end bit F/F -> byte_valid 4 cycles carrying A5,3C,00,FF, each 1 cycle after its input cycle; block_done 1 cycle after END with crc_err=0, end_err=0.
REQ-037 Scenario: same block with one CRC bit on lane 2 falling flipped -> block_done with crc_err=1, end_err=0, all 4 bytes still delivered.
REQ-038 Scenario: correct block but end cycle q0=F, q1=E -> block_done with end_err=1, crc_err=0.
REQ-039 Scenario: arm, lanes held at F -> timeout pulse exactly after 8 waiting cycles, busy falls the same cycle, no block_done, no byte_valid.
REQ-040 Scenario: RSTB pulsed during the 2nd data byte -> no further byte_valid, no block_done; a subsequent arm and good block then completes with both error flags 0.
REQ-041 Scenario: arm re-pulsed while in DATA -> ignored; block timing and results are identical to REQ-036.
